// File: rtl/cp0_unit_if.sv
// cp0_unit_if: M-stage <-> CP0 signal bundle.
//   master : pipeline side (drives M-stage instruction info, reads CP0 results)
//   slave  : cp0_unit side
// Signals:
//   m_valid, pc_m, bd_m, exc_valid, exc_code_in, eret_m, we, addr, wdata, hwint
//     -> M-stage instruction, exception, mtc0/mfc0 and interrupt inputs
//   rdata, req, handler_pc, epc_out, exl_out
//     -> mfc0 data, flush request, handler entry, EPC for eret, SR.EXL
interface cp0_unit_if;
  logic        m_valid;
  logic [31:0] pc_m;
  logic        bd_m;
  logic        exc_valid;
  logic [4:0]  exc_code_in;
  logic        eret_m;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [5:0]  hwint;
  logic [31:0] rdata;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;
  logic        exl_out;

  modport master (
    output m_valid, pc_m, bd_m, exc_valid, exc_code_in, eret_m, we, addr, wdata, hwint,
    input  rdata, req, handler_pc, epc_out, exl_out
  );

  modport slave (
    input  m_valid, pc_m, bd_m, exc_valid, exc_code_in, eret_m, we, addr, wdata, hwint,
    output rdata, req, handler_pc, epc_out, exl_out
  );
endinterface

// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor 0 resident in the M stage of the pipelined MIPS core.
// Decides exception/interrupt flushes, holds SR/Cause/EPC/PRId, serves mfc0
// data and provides EPC for eret.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high reset
//   cp0    : cp0_unit_if.slave bundle (M-stage inputs, rdata/req/handler_pc/
//            epc_out/exl_out outputs)
// Build option:
//   CP0_COUNT_EN : adds the free-running Count register (CP0 reg 9).
module cp0_unit #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL   = 32'h2020_0712
) (
  input logic       clk,
  input logic       reset,
  cp0_unit_if.slave cp0
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;
`ifdef CP0_COUNT_EN
  logic [31:0] count_q, count_d;
`endif

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  assign sr_val    = {16'h0, im_q, 8'h0, exl_q, ie_q};
  assign cause_val = {bd_q, 15'h0, ip_q, 3'b000, exc_code_q, 2'b00};

  always_comb begin
    int_req = cp0.m_valid & ie_q & ~exl_q & (|(cp0.hwint & im_q));
    exc_req = cp0.m_valid & cp0.exc_valid & ~exl_q;
    req     = int_req | exc_req;
  end

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    // IP samples the lines every cycle regardless of EXL.
    ip_d       = cp0.hwint;
`ifdef CP0_COUNT_EN
    count_d    = count_q + 32'd1;
`endif
    if (req) begin
      // A flushing instruction's mtc0/eret never take effect.
      exl_d      = 1'b1;
      exc_code_d = int_req ? 5'd0 : cp0.exc_code_in;
      bd_d       = cp0.bd_m;
      epc_d      = cp0.bd_m ? (cp0.pc_m - 32'd4) : cp0.pc_m;
    end else if (cp0.eret_m && cp0.m_valid) begin
      exl_d = 1'b0;
    end else if (cp0.we && cp0.m_valid) begin
      case (cp0.addr)
        5'd12: begin
          im_d  = cp0.wdata[15:10];
          exl_d = cp0.wdata[1];
          ie_d  = cp0.wdata[0];
        end
        5'd14: epc_d = cp0.wdata;
`ifdef CP0_COUNT_EN
        5'd9:  count_d = cp0.wdata;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
`ifdef CP0_COUNT_EN
      count_q    <= '0;
`endif
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
`ifdef CP0_COUNT_EN
      count_q    <= count_d;
`endif
    end
  end

  always_comb begin
    case (cp0.addr)
      5'd12:   cp0.rdata = sr_val;
      5'd13:   cp0.rdata = cause_val;
      5'd14:   cp0.rdata = epc_q;
      5'd15:   cp0.rdata = PRID_VAL;
`ifdef CP0_COUNT_EN
      5'd9:    cp0.rdata = count_q;
`endif
      default: cp0.rdata = 32'h0;
    endcase
  end

  assign cp0.req        = req;
  assign cp0.handler_pc = HANDLER_PC;
  assign cp0.epc_out    = epc_q;
  assign cp0.exl_out    = exl_q;

endmodule

// File: tb/tb_cp0_unit.sv
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h2020_0712;
  localparam logic [31:0] HPC  = 32'h0000_4180;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        t_mv, t_bd, t_ev, t_eret, t_we;
  logic [31:0] t_pc, t_wdata;
  logic [4:0]  t_code, t_addr;
  logic [5:0]  t_hw;

  cp0_unit_if bus ();
  assign bus.m_valid     = t_mv;
  assign bus.pc_m        = t_pc;
  assign bus.bd_m        = t_bd;
  assign bus.exc_valid   = t_ev;
  assign bus.exc_code_in = t_code;
  assign bus.eret_m      = t_eret;
  assign bus.we          = t_we;
  assign bus.addr        = t_addr;
  assign bus.wdata       = t_wdata;
  assign bus.hwint       = t_hw;

  cp0_unit dut (.clk(clk), .reset(reset), .cp0(bus));

  int total = 0;
  int bad   = 0;

  // reference model: architectural register values as 32-bit words
  logic [31:0] m_sr, m_cause, m_epc, m_count;

  function automatic logic m_int();
    return t_mv && m_sr[0] && !m_sr[1] && ((t_hw & m_sr[15:10]) != 6'd0);
  endfunction

  function automatic logic m_req();
    return m_int() || (t_mv && t_ev && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    case (a)
      5'd12: return m_sr;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return PRID;
`ifdef CP0_COUNT_EN
      5'd9:  return m_count;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_update();
    logic ir, rq, loaded;
    ir = m_int();
    rq = m_req();
    loaded = 1'b0;
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0;
    end else begin
      m_cause[15:10] = t_hw;
      if (rq) begin
        m_sr[1] = 1'b1;
        m_cause[6:2] = ir ? 5'd0 : t_code;
        m_cause[31] = t_bd;
        m_epc = t_bd ? t_pc - 32'd4 : t_pc;
      end else if (t_eret && t_mv) begin
        m_sr[1] = 1'b0;
      end else if (t_we && t_mv) begin
        if (t_addr == 5'd12) m_sr = t_wdata & 32'h0000_FC03;
        if (t_addr == 5'd14) m_epc = t_wdata;
`ifdef CP0_COUNT_EN
        if (t_addr == 5'd9) begin m_count = t_wdata; loaded = 1'b1; end
`endif
      end
      if (!loaded) m_count = m_count + 32'd1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, mv;
    logic [31:0] pc;
    logic        bd, ev;
    logic [4:0]  code;
    logic        eret, we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [5:0]  hw;
    logic        exp_req;
    logic [31:0] exp_rd;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic mv, input logic [31:0] pc,
                              input logic bd, input logic ev, input logic [4:0] code,
                              input logic eret, input logic we, input logic [4:0] addr,
                              input logic [31:0] wdata, input logic [5:0] hw,
                              input logic exp_req, input logic [31:0] exp_rd);
    vec_t v;
    v.rst = rst; v.mv = mv; v.pc = pc; v.bd = bd; v.ev = ev; v.code = code;
    v.eret = eret; v.we = we; v.addr = addr; v.wdata = wdata; v.hw = hw;
    v.exp_req = exp_req; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset = v.rst; t_mv = v.mv; t_pc = v.pc; t_bd = v.bd; t_ev = v.ev; t_code = v.code;
    t_eret = v.eret; t_we = v.we; t_addr = v.addr; t_wdata = v.wdata; t_hw = v.hw;
  endtask

  task automatic edge_and_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // table vector: req/rdata against constants, epc/exl against the model
  task automatic run_vec(input vec_t v, input string nm);
    drive(v);
    #4;
    chk({nm, "_req"}, {31'h0, bus.req}, {31'h0, v.exp_req});
    chk({nm, "_rdata"}, bus.rdata, v.exp_rd);
    chk({nm, "_epc"}, bus.epc_out, m_epc);
    chk({nm, "_exl"}, {31'h0, bus.exl_out}, {31'h0, m_sr[1]});
    edge_and_model();
  endtask

  vec_t tab[$];

  initial begin
    vec_t v;
    logic [4:0] codes[4];
    codes[0] = 5'd4; codes[1] = 5'd5; codes[2] = 5'd10; codes[3] = 5'd12;

    //                 rst mv pc            bd ev code eret we addr wdata         hw     req rd
    tab.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 0, 12, 32'h0,        6'd0, 0, 32'h0));
    tab.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 0, 13, 32'h0,        6'd0, 0, 32'h0));
    tab.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 0, 14, 32'h0,        6'd0, 0, 32'h0));
    tab.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 0, 15, 32'h0,        6'd0, 0, PRID));
    tab.push_back(mk(0, 1, 32'h3000,     0, 0, 0,  0, 1, 12, 32'h401,      6'd0, 0, 32'h0));
    tab.push_back(mk(0, 1, 32'h3010,     0, 0, 0,  0, 0, 12, 32'h0,        6'd1, 1, 32'h401));
    tab.push_back(mk(0, 1, 32'h3014,     0, 0, 0,  0, 0, 13, 32'h0,        6'd1, 0, 32'h400));
    tab.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 0, 14, 32'h0,        6'd0, 0, 32'h3010));
    tab.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 0, 12, 32'h0,        6'd0, 0, 32'h403));
    tab.push_back(mk(0, 1, 32'h3018,     0, 1, 12, 0, 0, 14, 32'h0,        6'd1, 0, 32'h3010));
    tab.push_back(mk(0, 1, 32'h301c,     0, 0, 0,  1, 0, 14, 32'h0,        6'd0, 0, 32'h3010));
    tab.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 0, 12, 32'h0,        6'd0, 0, 32'h401));
    tab.push_back(mk(0, 1, 32'h3024,     1, 1, 12, 0, 0, 13, 32'h0,        6'd0, 1, 32'h0));
    tab.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 0, 13, 32'h0,        6'd0, 0, 32'h8000_0030));
    tab.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 0, 14, 32'h0,        6'd0, 0, 32'h3020));
    tab.push_back(mk(0, 1, 32'h3028,     0, 0, 0,  1, 0, 12, 32'h0,        6'd0, 0, 32'h403));
    tab.push_back(mk(0, 1, 32'h3100,     0, 1, 10, 0, 1, 14, 32'h5555,     6'd1, 1, 32'h3020));
    tab.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 0, 14, 32'h0,        6'd0, 0, 32'h3100));
    tab.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 0, 13, 32'h0,        6'd0, 0, 32'h0));
    tab.push_back(mk(0, 1, 32'h3104,     0, 0, 0,  1, 0, 12, 32'h0,        6'd0, 0, 32'h403));
    tab.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 0, 12, 32'h0,        6'd1, 0, 32'h401));
    tab.push_back(mk(0, 1, 32'h3200,     1, 0, 0,  0, 0, 14, 32'h0,        6'd1, 1, 32'h3100));
    tab.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 0, 13, 32'h0,        6'd0, 0, 32'h8000_0400));
    tab.push_back(mk(0, 1, 32'h3204,     0, 0, 0,  0, 1, 12, 32'h401,      6'd1, 0, 32'h403));
    tab.push_back(mk(0, 1, 32'h3300,     0, 0, 0,  0, 0, 12, 32'h0,        6'd1, 1, 32'h401));
    tab.push_back(mk(1, 1, 32'h3304,     0, 0, 0,  1, 1, 14, 32'h7777,     6'd1, 0, 32'h3300));
    tab.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 0, 12, 32'h0,        6'd0, 0, 32'h0));
    tab.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 0, 14, 32'h0,        6'd0, 0, 32'h0));
    tab.push_back(mk(0, 1, 32'h0,        0, 0, 0,  0, 1, 13, 32'hFFFF_FFFF, 6'd0, 0, 32'h0));
    tab.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 0, 13, 32'h0,        6'd0, 0, 32'h0));
    tab.push_back(mk(0, 1, 32'h0,        0, 0, 0,  0, 1, 15, 32'h1234,     6'd0, 0, PRID));
    tab.push_back(mk(0, 1, 32'h0,        0, 0, 0,  0, 1, 7,  32'hFF,       6'd0, 0, 32'h0));
    tab.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 0, 7,  32'h0,        6'd0, 0, 32'h0));
    tab.push_back(mk(0, 1, 32'h0,        0, 0, 0,  0, 1, 12, 32'h801,      6'd0, 0, 32'h0));
    tab.push_back(mk(0, 1, 32'h3400,     0, 0, 0,  0, 0, 12, 32'h0,        6'd1, 0, 32'h801));
    tab.push_back(mk(0, 1, 32'h3404,     0, 0, 0,  0, 0, 14, 32'h0,        6'd2, 1, 32'h0));

    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    edge_and_model();
    edge_and_model();

    chk("handler_pc", bus.handler_pc, HPC);

    foreach (tab[i]) run_vec(tab[i], $sformatf("vec%0d", i));

    // Count register sequence
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0));
    edge_and_model();
`ifdef CP0_COUNT_EN
    for (int i = 0; i <= 5; i++)
      run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, i), $sformatf("count_after%0d", i));
    run_vec(mk(0, 1, 0, 0, 0, 0, 0, 1, 9, 32'hFFFF_FFFF, 0, 0, 32'd6), "count_load");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 32'hFFFF_FFFF), "count_loaded");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 32'h0), "count_wrap");
`else
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 32'h0), "no_count_rd");
    run_vec(mk(0, 1, 0, 0, 0, 0, 0, 1, 9, 32'h1234, 0, 0, 32'h0), "no_count_wr");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 32'h0), "no_count_rd2");
`endif

    // randomized phase against the reference model
    for (int n = 0; n < 600; n++) begin
      int pick;
      reset  = ($urandom_range(63) == 0);
      t_mv   = ($urandom_range(3) != 0);
      t_pc   = $urandom;
      t_bd   = $urandom_range(1);
      t_ev   = ($urandom_range(7) == 0);
      t_code = codes[$urandom_range(3)];
      t_eret = ($urandom_range(9) == 0);
      t_we   = !t_eret && ($urandom_range(3) == 0);
      pick   = $urandom_range(7);
      if (pick == 0) t_addr = 5'd9;
      else if (pick <= 4) t_addr = 5'(11 + pick);
      else t_addr = 5'($urandom_range(31));
      t_wdata = $urandom;
      t_hw    = ($urandom_range(2) == 0) ? 6'($urandom_range(63)) : 6'd0;
      #4;
      chk("rnd_req", {31'h0, bus.req}, {31'h0, m_req()});
      chk("rnd_rdata", bus.rdata, m_rd(t_addr));
      chk("rnd_epc", bus.epc_out, m_epc);
      chk("rnd_exl", {31'h0, bus.exl_out}, {31'h0, m_sr[1]});
      edge_and_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
